// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// instr_fetch_unit_pkg : next-PC select codes and fetch state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// ============================================================================
// pc_next_logic : combinational next-PC mux, sign-extended branch adder, PC+1
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_logic
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic [7:0]        disp,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  logic [ADDR_W-1:0] disp_sext;
  logic [ADDR_W-1:0] branch_pc;

  // Sums are truncated to ADDR_W bits, so wraparound falls out naturally.
  assign disp_sext = {{(ADDR_W-8){disp[7]}}, disp};
  assign branch_pc = pc + disp_sext;
  assign pc_plus1  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc = pc;
    case (pc_sel)
      PC_INC:    next_pc = pc_plus1;
      PC_BRANCH: next_pc = branch_pc;
      PC_JUMP:   next_pc = jump_addr;
      PC_HOLD:   next_pc = pc;
      default:   next_pc = pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC owner and 3-state fetch sequencer for sync-read memory
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCEn,
  input  logic [1:0]        PCState,
  input  logic [7:0]        Disp,
  input  logic [ADDR_W-1:0] JumpAddr,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemData,
  output logic [15:0]       Instr,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus1
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] next_pc;

  pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc        (pc_q),
    .pc_sel    (PCState),
    .disp      (Disp),
    .jump_addr (JumpAddr),
    .next_pc   (next_pc),
    .pc_plus1  (PCPlus1)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        valid_d = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        instr_d = MemData;
        valid_d = 1'b1;
        state_d = READY;
      end
      READY: begin
        // Instr is frozen here; only an accepted advance drops valid.
        if (PCEn) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  assign MemAddr    = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural PC/memory model
// predicts PC, Instr and the valid timing of every advance.
`default_nettype none

module tb_instr_fetch_unit;

  localparam int ADDR_W = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              PCEn = 1'b0;
  logic [1:0]        PCState = 2'b00;
  logic [7:0]        Disp = 8'h00;
  logic [ADDR_W-1:0] JumpAddr = '0;
  logic [ADDR_W-1:0] MemAddr;
  logic [15:0]       MemData;
  logic [15:0]       Instr;
  logic              InstrValid;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus1;

  logic [15:0] mem [0:65535];
  int passed = 0;
  int total  = 0;
  int exp_pc = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PCEn       (PCEn),
    .PCState    (PCState),
    .Disp       (Disp),
    .JumpAddr   (JumpAddr),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus1    (PCPlus1)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read memory: data for the sampled address appears next cycle.
  always @(posedge Clk) MemData <= mem[MemAddr];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One accepted advance; optional PCEn noise while fetching must be ignored.
  task automatic advance(input logic [1:0] sel, input logic [7:0] d,
                         input logic [15:0] ja, input bit noise, input string nm);
    logic [15:0] old_instr;
    logic [15:0] e;
    int t;
    old_instr = Instr;
    case (sel)
      2'b00:   t = exp_pc + 1;
      2'b01:   t = exp_pc + int'($signed(d));
      2'b10:   t = int'(ja);
      default: t = exp_pc;
    endcase
    exp_pc = t & 32'hFFFF;
    e = exp_pc[15:0];
    PCEn = 1'b1; PCState = sel; Disp = d; JumpAddr = ja;
    tick();
    PCEn = noise ? 1'($urandom) : 1'b0;
    PCState = 2'($urandom); Disp = 8'($urandom); JumpAddr = 16'($urandom);
    total++;
    if (PC !== e || MemAddr !== e || InstrValid !== 1'b0)
      $display("FAIL %s edgeN: PC=%h MemAddr=%h valid=%b expected PC=%h valid=0",
               nm, PC, MemAddr, InstrValid, e);
    else passed++;
    tick();
    PCEn = noise ? 1'($urandom) : 1'b0;
    JumpAddr = 16'($urandom); PCState = 2'($urandom);
    total++;
    if (InstrValid !== 1'b0 || Instr !== old_instr || PC !== e)
      $display("FAIL %s edgeN+1: valid=%b Instr=%h PC=%h expected valid=0 Instr=%h PC=%h",
               nm, InstrValid, Instr, PC, old_instr, e);
    else passed++;
    tick();
    PCEn = 1'b0;
    total++;
    if (InstrValid !== 1'b1 || Instr !== mem[e] || PC !== e || PCPlus1 !== e + 16'd1)
      $display("FAIL %s edgeN+2: valid=%b Instr=%h PC=%h PCPlus1=%h expected valid=1 Instr=%h PC=%h PCPlus1=%h",
               nm, InstrValid, Instr, PC, PCPlus1, mem[e], e, e + 16'd1);
    else passed++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    total++;
    if (PC !== 16'h0000 || MemAddr !== 16'h0000 || Instr !== 16'h0000 ||
        InstrValid !== 1'b0 || PCPlus1 !== 16'h0001)
      $display("FAIL reset_values: PC=%h MemAddr=%h Instr=%h valid=%b PCPlus1=%h expected 0000/0000/0000/0/0001",
               PC, MemAddr, Instr, InstrValid, PCPlus1);
    else passed++;
    Reset = 1'b0;
    tick();
    total++;
    if (InstrValid !== 1'b0)
      $display("FAIL reset_fetch: valid=%b expected 0", InstrValid);
    else passed++;
    tick();
    total++;
    if (InstrValid !== 1'b1 || PC !== 16'h0000 || Instr !== mem[0])
      $display("FAIL reset_first_word: valid=%b PC=%h Instr=%h expected 1/0000/%h",
               InstrValid, PC, Instr, mem[0]);
    else passed++;
    exp_pc = 0;
  endtask

  task automatic test_hold_stable();
    logic [15:0] held;
    held = Instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (InstrValid !== 1'b1 || Instr !== held || PC !== exp_pc[15:0])
        $display("FAIL ready_stable: valid=%b Instr=%h PC=%h expected 1/%h/%h",
                 InstrValid, Instr, PC, held, exp_pc[15:0]);
      else passed++;
    end
  endtask

  task automatic test_increment();
    advance(2'b10, 8'h00, 16'h0005, 1'b0, "jump_to_5");
    advance(2'b00, 8'h00, 16'h0000, 1'b0, "inc_5_to_6");
    advance(2'b10, 8'h00, 16'hFFFF, 1'b0, "jump_to_ffff");
    advance(2'b00, 8'h00, 16'h0000, 1'b0, "inc_wrap");
  endtask

  task automatic test_branch();
    advance(2'b10, 8'h00, 16'h0010, 1'b0, "jump_to_0010");
    advance(2'b01, 8'hFC, 16'h0000, 1'b0, "branch_back_4");
    advance(2'b10, 8'h00, 16'hFFF0, 1'b0, "jump_to_fff0");
    advance(2'b01, 8'h7F, 16'h0000, 1'b0, "branch_fwd_wrap");
    advance(2'b10, 8'h00, 16'h0000, 1'b0, "jump_to_0");
    advance(2'b01, 8'hFF, 16'h0000, 1'b0, "branch_under_wrap");
  endtask

  task automatic test_jump_hold();
    advance(2'b10, 8'h00, 16'h1234, 1'b0, "jump_1234");
    // Change the backing word so a real refetch is observable.
    mem[16'h1234] = ~mem[16'h1234];
    advance(2'b11, 8'h00, 16'h0000, 1'b0, "hold_refetch");
  endtask

  task automatic test_pcen_ignored();
    for (int i = 0; i < 4; i++)
      advance(2'b00, 8'h00, 16'h0000, 1'b1, "pcen_noise");
  endtask

  task automatic test_reset_with_pcen();
    advance(2'b10, 8'h00, 16'h4321, 1'b0, "jump_pre_reset");
    Reset = 1'b1; PCEn = 1'b1; PCState = 2'b10; JumpAddr = 16'h7777;
    tick();
    Reset = 1'b0; PCEn = 1'b0;
    total++;
    if (PC !== 16'h0000 || MemAddr !== 16'h0000 || InstrValid !== 1'b0)
      $display("FAIL reset_with_pcen: PC=%h MemAddr=%h valid=%b expected 0000/0000/0",
               PC, MemAddr, InstrValid);
    else passed++;
    tick(); tick();
    total++;
    if (InstrValid !== 1'b1 || Instr !== mem[0] || PC !== 16'h0000)
      $display("FAIL reset_refetch: valid=%b Instr=%h PC=%h expected 1/%h/0000",
               InstrValid, Instr, PC, mem[0]);
    else passed++;
    exp_pc = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      advance(2'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), "random");
      repeat ($urandom_range(0, 2)) begin
        tick();
        total++;
        if (InstrValid !== 1'b1 || PC !== exp_pc[15:0] || Instr !== mem[exp_pc[15:0]])
          $display("FAIL random_idle: valid=%b PC=%h Instr=%h expected 1/%h/%h",
                   InstrValid, PC, Instr, exp_pc[15:0], mem[exp_pc[15:0]]);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    test_reset();
    test_hold_stable();
    test_increment();
    test_branch();
    test_jump_hold();
    test_pcen_ignored();
    test_reset_with_pcen();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
